// File: rtl/decoder_pkg.sv
// Shared definitions for the U-Net decoder stages: Q8.8 constants, FSM states
// and the saturating Q8.8 adder.
package decoder_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [15:0] ONE = 16'h0100;
  localparam logic [15:0] MAX = 16'h7FFF;
  localparam logic [15:0] MIN = 16'h8000;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCapt,
    StOut,
    StFin
  } state_e;

  // 17-bit signed sum clamped back into the Q8.8 range
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {a[15], a} + {b[15], b};
    if (sum[16] != sum[15]) begin
      return sum[16] ? MIN : MAX;
    end
    return sum[15:0];
  endfunction

endpackage

// File: rtl/fxp_add_sat_relu.sv
// Combinational signed add with saturation and optional ReLU on the clamped result.
module fxp_add_sat_relu #(
  parameter int unsigned DATA_W  = 16,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y
);

  import decoder_pkg::*;

  logic [DATA_W-1:0] w_sat;

  if (DATA_W == 16) begin : g_q88
    assign w_sat = sat_add16(i_a, i_b);
  end else begin : g_generic
    logic [DATA_W:0] w_sum;
    assign w_sum = {i_a[DATA_W-1], i_a} + {i_b[DATA_W-1], i_b};
    // Overflow when the two top bits disagree; clamp toward the sign of the true sum
    assign w_sat = (w_sum[DATA_W] != w_sum[DATA_W-1]) ?
                   {w_sum[DATA_W], {(DATA_W-1){~w_sum[DATA_W]}}} : w_sum[DATA_W-1:0];
  end

  assign o_y = (RELU_EN && w_sat[DATA_W-1]) ? '0 : w_sat;

endmodule

// File: rtl/decoder_upsample_skip.sv
// Decoder fusion step: 2x nearest-neighbour upsample of the deep map added to the
// encoder skip map, saturated, optionally ReLU'd, streamed out over valid/ready.
module decoder_upsample_skip #(
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned OUT_HEIGHT = 16,
  parameter int unsigned CHANNELS   = 64,
  parameter int unsigned DATA_W     = 16,
  parameter bit          RELU_EN    = 1'b1,
  localparam int unsigned DEEP_AW = $clog2((OUT_WIDTH / 2) * (OUT_HEIGHT / 2) * CHANNELS),
  localparam int unsigned SKIP_AW = $clog2(OUT_WIDTH * OUT_HEIGHT * CHANNELS)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_deep_rd_en,
  output logic [DEEP_AW-1:0] o_deep_addr,
  input  logic [DATA_W-1:0]  i_deep_rdata,
  output logic               o_skip_rd_en,
  output logic [SKIP_AW-1:0] o_skip_addr,
  input  logic [DATA_W-1:0]  i_skip_rdata,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [DATA_W-1:0]  o_out_data,
  output logic               o_out_last
);

  import decoder_pkg::*;

  localparam int unsigned YW = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
  localparam int unsigned XW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_e            r_state, w_state_next;
  logic [YW-1:0]     r_y, w_y_next;
  logic [XW-1:0]     r_x, w_x_next;
  logic [CW-1:0]     r_c, w_c_next;
  logic [DATA_W-1:0] r_data, w_data_next;
  logic              r_valid, w_valid_next;
  logic              r_last, w_last_next;

  logic [DATA_W-1:0] w_fused;
  logic              w_c_end, w_x_end, w_y_end, w_at_last;

  fxp_add_sat_relu #(
    .DATA_W  (DATA_W),
    .RELU_EN (RELU_EN)
  ) u_add (
    .i_a (i_deep_rdata),
    .i_b (i_skip_rdata),
    .o_y (w_fused)
  );

  assign w_c_end   = (r_c == CW'(CHANNELS - 1));
  assign w_x_end   = (r_x == XW'(OUT_WIDTH - 1));
  assign w_y_end   = (r_y == YW'(OUT_HEIGHT - 1));
  assign w_at_last = w_c_end && w_x_end && w_y_end;

  // Addresses follow the counters, which hold still while a beat waits in OUT
  assign o_skip_addr = SKIP_AW'((32'(r_y) * OUT_WIDTH + 32'(r_x)) * CHANNELS + 32'(r_c));
  assign o_deep_addr = DEEP_AW'((32'(r_y >> 1) * (OUT_WIDTH / 2) + 32'(r_x >> 1)) * CHANNELS
                                + 32'(r_c));

  assign o_deep_rd_en = (r_state == StRead);
  assign o_skip_rd_en = (r_state == StRead);
  assign o_busy       = (r_state == StRead) || (r_state == StCapt) || (r_state == StOut);
  assign o_done       = (r_state == StFin);
  assign o_out_valid  = r_valid;
  assign o_out_data   = r_data;
  assign o_out_last   = r_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_y     <= '0;
      r_x     <= '0;
      r_c     <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_y     <= w_y_next;
      r_x     <= w_x_next;
      r_c     <= w_c_next;
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
      r_last  <= w_last_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_y_next     = r_y;
    w_x_next     = r_x;
    w_c_next     = r_c;
    w_data_next  = r_data;
    w_valid_next = r_valid;
    w_last_next  = r_last;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = StRead;
          w_y_next     = '0;
          w_x_next     = '0;
          w_c_next     = '0;
        end
      end
      StRead: w_state_next = StCapt;
      StCapt: begin
        w_data_next  = w_fused;
        w_valid_next = 1'b1;
        w_last_next  = w_at_last;
        w_state_next = StOut;
      end
      StOut: begin
        if (i_out_ready) begin
          w_valid_next = 1'b0;
          w_last_next  = 1'b0;
          if (w_at_last) begin
            w_state_next = StFin;
          end else begin
            w_state_next = StRead;
            // c innermost, then x, then y
            if (w_c_end) begin
              w_c_next = '0;
              if (w_x_end) begin
                w_x_next = '0;
                w_y_next = r_y + 1'b1;
              end else begin
                w_x_next = r_x + 1'b1;
              end
            end else begin
              w_c_next = r_c + 1'b1;
            end
          end
        end
      end
      StFin:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

endmodule
